// File: rtl/vj_pkg.sv
// vj_pkg: window constants, integral-image data types and scan FSM states.
// The S_SQRT state exists only when WIN_STD_SQRT_EN is defined.
package vj_pkg;
    localparam int WIN_SIZE      = 24;
    localparam int WIN_AREA      = WIN_SIZE * WIN_SIZE;
    localparam int LAPTOP_WIDTH  = 1280;
    localparam int LAPTOP_HEIGHT = 720;
    typedef logic [31:0] ii_t;
    typedef logic [63:0] var_t;
    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WAIT, S_CALC,
`ifdef WIN_STD_SQRT_EN
        S_SQRT,
`endif
        S_OUT
    } state_t;
endpackage

// File: rtl/window_var_scan_isqrt_seq.sv
// isqrt_seq: sequential integer square root, one result bit per cycle over 32 cycles.
// Compiled only when WIN_STD_SQRT_EN is defined.
`ifdef WIN_STD_SQRT_EN
module isqrt_seq
    import vj_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  var_t radicand,
    output logic done,
    output ii_t  root
);
    var_t        op;
    logic [35:0] rem;
    logic [35:0] rem_sh;
    logic [35:0] trial;
    logic [5:0]  cnt;
    logic        active;
    logic        fits;

    always_comb begin
        rem_sh = {rem[33:0], op[63:62]};
        trial  = {2'b00, root, 2'b01};
        fits   = rem_sh >= trial;
    end

    assign done = active && cnt == 6'd31;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op     <= '0;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            op     <= radicand;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            op     <= op << 2;
            rem    <= fits ? rem_sh - trial : rem_sh;
            root   <= {root[30:0], fits};
            cnt    <= cnt + 6'd1;
            active <= !done;
        end
    end
endmodule
`endif

// File: rtl/window_var_scan.sv
// window_var_scan: scans every WIN_SIZE window of an integral image and reports sum and variance.
// Defining WIN_STD_SQRT_EN adds a SQRT state producing win_std = floor(sqrt(win_var)).
module window_var_scan
    import vj_pkg::*;
#(
    parameter int WIDTH_LIMIT  = LAPTOP_WIDTH,
    parameter int HEIGHT_LIMIT = LAPTOP_HEIGHT,
    localparam int CW = $clog2(WIDTH_LIMIT),
    localparam int RW = $clog2(HEIGHT_LIMIT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          rd_en,
    output logic [RW-1:0] rd_row,
    output logic [CW-1:0] rd_col,
    input  ii_t           rd_ii,
    input  ii_t           rd_ii_sq,
    output logic [CW-1:0] win_x,
    output logic [RW-1:0] win_y,
    output ii_t           win_sum,
    output var_t          win_var,
    output ii_t           win_std,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);
    localparam logic [CW-1:0] X_MAX = CW'(WIDTH_LIMIT - WIN_SIZE);
    localparam logic [RW-1:0] Y_MAX = RW'(HEIGHT_LIMIT - WIN_SIZE);

    state_t        state, state_nx;
    logic [CW-1:0] x_pos;
    logic [RW-1:0] y_pos;
    ii_t           acc_sum, acc_sq, cap_ii, cap_sq;
    var_t          var_c;
    logic          rd_en_q, last, hs;
`ifdef WIN_STD_SQRT_EN
    logic          iq_done;
`endif

    assign last   = x_pos == X_MAX && y_pos == Y_MAX;
    assign hs     = state == S_OUT && out_ready;
    assign cap_ii = rd_en_q ? rd_ii : '0;
    assign cap_sq = rd_en_q ? rd_ii_sq : '0;
    assign var_c  = var_t'(WIN_AREA) * var_t'(acc_sq) - var_t'(acc_sum) * var_t'(acc_sum);
    assign win_x  = x_pos;
    assign win_y  = y_pos;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: state_nx = start ? S_RD0 : S_IDLE;
            S_RD0:  state_nx = S_RD1;
            S_RD1:  state_nx = S_RD2;
            S_RD2:  state_nx = S_RD3;
            S_RD3:  state_nx = S_WAIT;
            S_WAIT: state_nx = S_CALC;
`ifdef WIN_STD_SQRT_EN
            S_CALC: state_nx = S_SQRT;
            S_SQRT: state_nx = iq_done ? S_OUT : S_SQRT;
`else
            S_CALC: state_nx = S_OUT;
`endif
            S_OUT:  state_nx = out_ready ? (last ? S_IDLE : S_RD0) : S_OUT;
            default: state_nx = S_IDLE;
        endcase
    end

    // Corners on row or column -1 are never read; they contribute zero.
    always_comb begin
        rd_en = state == S_RD0 || (state == S_RD1 && y_pos != '0) ||
                (state == S_RD2 && x_pos != '0) ||
                (state == S_RD3 && x_pos != '0 && y_pos != '0);
        rd_row = !rd_en ? '0 : (state == S_RD0 || state == S_RD2) ?
                 y_pos + RW'(WIN_SIZE - 1) : y_pos - RW'(1);
        rd_col = !rd_en ? '0 : (state == S_RD0 || state == S_RD1) ?
                 x_pos + CW'(WIN_SIZE - 1) : x_pos - CW'(1);
        out_valid = state == S_OUT;
        busy      = state != S_IDLE;
    end

    // Read data arrives one cycle after issue, so D lands in RD1 and A in WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_pos   <= '0;
            y_pos   <= '0;
            acc_sum <= '0;
            acc_sq  <= '0;
            rd_en_q <= 1'b0;
            win_sum <= '0;
            win_var <= '0;
            done    <= 1'b0;
        end else begin
            rd_en_q <= rd_en;
            done    <= hs && last;
            if (state == S_IDLE && start) begin
                x_pos <= '0;
                y_pos <= '0;
            end else if (hs && !last) begin
                x_pos <= x_pos == X_MAX ? '0 : x_pos + CW'(1);
                y_pos <= x_pos == X_MAX ? y_pos + RW'(1) : y_pos;
            end
            acc_sum <= state == S_RD1 ? cap_ii :
                       (state == S_RD2 || state == S_RD3) ? acc_sum - cap_ii :
                       state == S_WAIT ? acc_sum + cap_ii : acc_sum;
            acc_sq  <= state == S_RD1 ? cap_sq :
                       (state == S_RD2 || state == S_RD3) ? acc_sq - cap_sq :
                       state == S_WAIT ? acc_sq + cap_sq : acc_sq;
            if (state == S_CALC) begin
                win_sum <= acc_sum;
                win_var <= var_c;
            end
        end
    end

`ifdef WIN_STD_SQRT_EN
    isqrt_seq u_isqrt (
        .clock    (clock),
        .reset    (reset),
        .start    (state == S_CALC),
        .radicand (var_c),
        .done     (iq_done),
        .root     (win_std)
    );
`else
    assign win_std = '0;
`endif
endmodule

// File: tb/tb_window_var_scan.sv
// tb_window_var_scan: directed bench on a 26x25 image with two pixel patterns, stall and mid-scan reset.
module tb_window_var_scan;
    localparam int W = 26;
    localparam int H = 25;
`ifdef WIN_STD_SQRT_EN
    localparam int LAT = 38;
    localparam bit SQ  = 1'b1;
`else
    localparam int LAT = 6;
    localparam bit SQ  = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic        rd_en, out_valid, busy, done;
    logic [4:0]  rd_row, win_y;
    logic [4:0]  rd_col, win_x;
    logic [31:0] rd_ii = '0, rd_ii_sq = '0, win_sum, win_std;
    logic [63:0] win_var;
    int          mode = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    window_var_scan #(.WIDTH_LIMIT(W), .HEIGHT_LIMIT(H)) dut (
        .clock(clock), .reset(reset), .start(start), .rd_en(rd_en),
        .rd_row(rd_row), .rd_col(rd_col), .rd_ii(rd_ii), .rd_ii_sq(rd_ii_sq),
        .win_x(win_x), .win_y(win_y), .win_sum(win_sum), .win_var(win_var),
        .win_std(win_std), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // mode 0: every pixel 1; mode 1: pixel 2 on odd columns, 0 on even columns
    function automatic logic [31:0] ii_of(input int r, input int c);
        return mode != 0 ? 32'(2 * ((c + 1) / 2) * (r + 1)) : 32'((r + 1) * (c + 1));
    endfunction
    function automatic logic [31:0] sq_of(input int r, input int c);
        return mode != 0 ? 32'(4 * ((c + 1) / 2) * (r + 1)) : 32'((r + 1) * (c + 1));
    endfunction

    always @(posedge clock) begin
        rd_ii    <= rd_en ? ii_of(int'(rd_row), int'(rd_col)) : '0;
        rd_ii_sq <= rd_en ? sq_of(int'(rd_row), int'(rd_col)) : '0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " out_valid"}, 64'(out_valid), 0);
        check({tag, " rd_en"}, 64'(rd_en), 0);
        check({tag, " busy"}, 64'(busy), 0);
        check({tag, " done"}, 64'(done), 0);
        check({tag, " win_x"}, 64'(win_x), 0);
        check({tag, " win_y"}, 64'(win_y), 0);
        check({tag, " win_sum"}, 64'(win_sum), 0);
        check({tag, " win_var"}, win_var, 0);
        check({tag, " win_std"}, 64'(win_std), 0);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Entered just before the window's RD0 cycle; returns at the OUT cycle with out_ready high.
    task automatic do_window(input int ex, input int ey, input int stall);
        logic        en;
        int          lat;
        logic [63:0] xv, sv, vv;
        string       t;
        t = $sformatf("w(%0d,%0d)", ex, ey);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k == 0 && stall > 0) out_ready = 1'b0;
            en = k == 0 || (k == 1 && ey != 0) || (k == 2 && ex != 0) || (k == 3 && ex != 0 && ey != 0);
            check($sformatf("%s rd_en c%0d", t, k), 64'(rd_en), 64'(en));
            if (en) begin
                check($sformatf("%s rd_row c%0d", t, k), 64'(rd_row), (k == 0 || k == 2) ? 64'(ey + 23) : 64'(ey - 1));
                check($sformatf("%s rd_col c%0d", t, k), 64'(rd_col), (k < 2) ? 64'(ex + 23) : 64'(ex - 1));
            end
        end
        lat = 3;
        while (!out_valid && lat < 80) begin
            @(negedge clock);
            lat++;
        end
        check({t, " latency"}, 64'(lat), 64'(LAT));
        check({t, " win_x"}, 64'(win_x), 64'(ex));
        check({t, " win_y"}, 64'(win_y), 64'(ey));
        check({t, " win_sum"}, 64'(win_sum), 576);
        check({t, " win_var"}, win_var, mode != 0 ? 64'd331776 : 64'd0);
        check({t, " win_std"}, 64'(win_std), (SQ && mode != 0) ? 64'd576 : 64'd0);
        xv = 64'(win_x);
        sv = 64'(win_sum);
        vv = win_var;
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            start = (i == 3);
            check({t, " stall valid"}, 64'(out_valid), 1);
            check({t, " stall win_x"}, 64'(win_x), xv);
            check({t, " stall win_sum"}, 64'(win_sum), sv);
            check({t, " stall win_var"}, win_var, vv);
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic full_scan(input int stall_idx);
        pulse_start();
        for (int i = 0; i < 6; i++) do_window(i % 3, i / 3, i == stall_idx ? 10 : 0);
        @(negedge clock);
        check("done pulse", 64'(done), 1);
        check("idle busy", 64'(busy), 0);
        @(negedge clock);
        check("done cleared", 64'(done), 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle no start busy", 64'(busy), 0);

        mode = 0;
        full_scan(2);
        mode = 1;
        full_scan(-1);

        mode = 0;
        pulse_start();
        for (int i = 0; i < 4; i++) do_window(i % 3, i / 3, 0);
        repeat (3) @(negedge clock);
        check("pre-reset rd_en in RD2", 64'(rd_en), 1);
        check("pre-reset win_sum", 64'(win_sum), 576);
        reset = 1'b1;
        #1 check_zero("mid reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_zero("post reset");
        full_scan(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/window_var_scan.md
WINDOW_VAR_SCAN -- requirements
Module: window_var_scan

Interface
REQ-001 SHALL have parameter WIDTH_LIMIT, default LAPTOP_WIDTH, integral-image width in pixels.
REQ-002 SHALL have parameter HEIGHT_LIMIT, default LAPTOP_HEIGHT, integral-image height in pixels.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins a frame scan; ignored unless IDLE.
REQ-006 SHALL have port rd_en  output  1  integral-image read request.
REQ-007 SHALL have ports rd_row, rd_col  output  clog2(HEIGHT_LIMIT), clog2(WIDTH_LIMIT)  read address.
REQ-008 SHALL have ports rd_ii, rd_ii_sq  input  32 each  integral and squared-integral data, valid exactly 1 cycle after rd_en.
REQ-009 SHALL have ports win_x, win_y  output  clog2(WIDTH_LIMIT), clog2(HEIGHT_LIMIT)  top-left of reported window.
REQ-010 SHALL have ports win_sum  output  32  window pixel sum; win_var  output  64  WIN_AREA*sqsum - sum^2; win_std  output  32  integer sqrt of win_var.
REQ-011 SHALL have ports out_valid  output  1; out_ready  input  1; busy  output  1; done  output  1  one-cycle pulse.

Function
REQ-012 SHALL scan windows of WIN_SIZE x WIN_SIZE, step 1: y outer 0..HEIGHT_LIMIT-WIN_SIZE, x inner 0..WIDTH_LIMIT-WIN_SIZE.
REQ-013 SHALL use inclusive integral images: corners D=(y+W-1,x+W-1), B=(y-1,x+W-1), C=(y+W-1,x-1), A=(y-1,x-1), W=WIN_SIZE.
REQ-014 SHALL compute sum = D-B-C+A and sqsum likewise, in 32-bit modular arithmetic.
REQ-015 SHALL treat any corner with row or column -1 as 0, holding rd_en low in that corner's issue cycle.
REQ-016 SHALL implement FSM IDLE -> RD0(D) -> RD1(B) -> RD2(C) -> RD3(A) -> WAIT -> CALC -> [SQRT] -> OUT.
REQ-017 SHALL leave OUT for RD0 of the next window on out_valid&&out_ready, or for IDLE after the last window.
REQ-018 SHALL capture read data in the cycle after each issue cycle.
REQ-019 SHALL compute win_var in CALC as 64-bit unsigned WIN_AREA*sqsum - sum*sum.
REQ-020 SHALL, without the macro, assert out_valid exactly 6 cycles after the window's RD0 cycle.
REQ-021 SHALL hold win_* stable while out_valid=1 and out_ready=0, and never drop out_valid without a handshake.
REQ-022 SHALL pulse done in the cycle after the final handshake.
REQ-023 SHALL assert busy in every non-IDLE state.

Reset
REQ-024 SHALL, on reset at any time including mid-scan, enter IDLE with out_valid, rd_en, busy, done, win_x, win_y, win_sum, win_var, win_std all 0.
REQ-025 SHALL require a new start after reset; no partial window is ever emitted.

Configuration
REQ-026 SHALL compile SQRT state and isqrt instance only when WIN_STD_SQRT_EN is defined.
REQ-027 SHALL, with WIN_STD_SQRT_EN, set win_std = floor(sqrt(win_var)) and delay out_valid 32 further cycles (38 after RD0).
REQ-028 SHALL, without WIN_STD_SQRT_EN, tie win_std to 0.

Structure
REQ-029 SHALL take WIN_SIZE (24), WIN_AREA (576), ii_t (32-bit) and var_t (64-bit) from shared package vj_pkg.
REQ-030 SHALL place the square root in sub-module isqrt_seq: start/done handshake, one result bit per cycle, 32 cycles.

Verification
REQ-031 SHALL test: all pixels 1, ii[r][c]=(r+1)(c+1) -> every window sum=576, var=0, std=0.
REQ-032 SHALL test: pixel=2 on odd columns, 0 on even -> sum=576, var=331776, std=576 (std checked only with macro).
REQ-033 SHALL test: WIDTH_LIMIT=26, HEIGHT_LIMIT=25 -> 6 windows, order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), then done pulse.
REQ-034 SHALL test window (0,0): only D issued, at (23,23); window (1,1): all four of (24,24),(0,24),(24,0),(0,0) issued.
REQ-035 SHALL test out_ready low for 10 cycles -> outputs stable, no window lost or duplicated; start pulsed while busy -> ignored.
REQ-036 SHALL test reset asserted in RD2 -> IDLE, all outputs 0 next cycle; a later start rescans from (0,0).
